// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C target and its bus monitor.
package i2c_pkg;

    localparam int ADDR_W = 7;

    localparam logic I2C_READ  = 1'b1;
    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_ACK   = 1'b0;
    localparam logic I2C_NACK  = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        WRITE     = 3'd3,
        WRITE_ACK = 3'd4,
        READ      = 3'd5,
        READ_ACK  = 3'd6,
        IGNORE    = 3'd7
    } state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with edge, START and STOP detection on the oversampling clock.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic refresh_clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_dly_q;
    logic                   sda_dly_q;
    logic                   scl_s;

    // Synchronizers reset to the idle bus level so reset release never looks like an edge.
    always_ff @(posedge refresh_clk or negedge reset) begin
        if (!reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_dly_q  <= 1'b1;
            sda_dly_q  <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
            scl_dly_q  <= scl_sync_q[SYNC_STAGES-1];
            sda_dly_q  <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_dly_q;
    assign scl_fall  = ~scl_s & scl_dly_q;
    assign start_det = scl_s & sda_dly_q & ~sda_s;
    assign stop_det  = scl_s & ~sda_dly_q & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: address match, ACK generation, byte receive and byte transmit over open-drain SDA.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SLAVE_ADDR  = 7'h2A,
    parameter int                SYNC_STAGES = 2
) (
    input  logic       refresh_clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       rw,
    output logic       busy,
    output logic       stop_det
);

    logic scl_rise, scl_fall, sda_s, bus_start, bus_stop;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .refresh_clk (refresh_clk),
        .reset       (reset),
        .scl         (scl),
        .sda         (sda),
        .scl_rise    (scl_rise),
        .scl_fall    (scl_fall),
        .sda_s       (sda_s),
        .start_det   (bus_start),
        .stop_det    (bus_stop)
    );

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;
    logic       stop_det_q, stop_det_d;
    logic       sda_oe_q, sda_oe_d;
    logic       phase_q, phase_d;
    logic       tx_load;
    logic [7:0] byte_in;

    assign byte_in = {shift_q[6:0], sda_s};

    // phase_q splits the two scl_fall steps of each ACK slot (drive, then hand over).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rw_d       = rw_q;
        busy_d     = busy_q;
        stop_det_d = 1'b0;
        sda_oe_d   = sda_oe_q;
        phase_d    = phase_q;
        tx_load    = 1'b0;
        if (bus_stop) begin
            state_d    = IDLE;
            cnt_d      = 4'd0;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            stop_det_d = 1'b1;
        end else if (bus_start) begin
            state_d  = ADDR;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = 4'd0;
                            if (byte_in[7:1] == SLAVE_ADDR) begin
                                rw_d    = byte_in[0];
                                busy_d  = 1'b1;
                                phase_d = 1'b0;
                                state_d = ADDR_ACK;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = IGNORE;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                            if (rw_q == I2C_READ) begin
                                tx_load = 1'b1;
                                shift_d = tx_data;
                            end
                        end else begin
                            phase_d = 1'b0;
                            cnt_d   = 4'd0;
                            if (rw_q == I2C_READ) begin
                                sda_oe_d = ~shift_q[7];
                                state_d  = READ;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = WRITE;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d      = 4'd0;
                            rx_data_d  = byte_in;
                            rx_valid_d = 1'b1;
                            phase_d    = 1'b0;
                            state_d    = WRITE_ACK;
                        end
                    end
                end
                WRITE_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            phase_d  = 1'b0;
                            state_d  = WRITE;
                        end
                    end
                end
                READ: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd7) begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 4'd0;
                            phase_d  = 1'b0;
                            state_d  = READ_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                            cnt_d    = cnt_q + 4'd1;
                        end
                    end
                end
                READ_ACK: begin
                    if (!phase_q) begin
                        if (scl_rise) begin
                            if (sda_s == I2C_ACK) begin
                                tx_load = 1'b1;
                                shift_d = tx_data;
                                phase_d = 1'b1;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = IGNORE;
                            end
                        end
                    end else if (scl_fall) begin
                        sda_oe_d = ~shift_q[7];
                        phase_d  = 1'b0;
                        cnt_d    = 4'd0;
                        state_d  = READ;
                    end
                end
                IGNORE:  sda_oe_d = 1'b0;
                default: state_d  = IDLE;
            endcase
        end
    end

    always_ff @(posedge refresh_clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 8'd0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
            stop_det_q <= 1'b0;
            sda_oe_q   <= 1'b0;
            phase_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
            stop_det_q <= stop_det_d;
            sda_oe_q   <= sda_oe_d;
            phase_q    <= phase_d;
        end
    end

    assign sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_load;
    assign rw       = rw_q;
    assign busy     = busy_q;
    assign stop_det = stop_det_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bus-level master plus a transaction model of the target.
module tb_i2c_slave;

    localparam int Q = 4;

    logic       refresh_clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       m_low;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid, tx_req, rw, busy, stop_det;
    wire        sda;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always #5 refresh_clk = ~refresh_clk;

    i2c_slave #(.SLAVE_ADDR(7'h2A), .SYNC_STAGES(2)) dut (
        .refresh_clk (refresh_clk),
        .reset       (reset),
        .scl         (scl),
        .sda         (sda),
        .tx_data     (tx_data),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_req      (tx_req),
        .rw          (rw),
        .busy        (busy),
        .stop_det    (stop_det)
    );

    int nvec = 0;
    int nerr = 0;

    // Transaction model of the target
    logic       m_busy = 1'b0;
    logic       m_rw   = 1'b0;
    logic       m_first = 1'b0;
    logic [7:0] m_addr = 8'h00;
    logic [7:0] exp_rx_q[$];
    logic [7:0] tx_q[$];
    int         m_tx_exp = 0;
    int         m_stop_exp = 0;
    int         tx_seen = 0;
    int         stop_seen = 0;
    logic       rd_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output checker: pulses on every cycle, busy/rw/SDA once the model has been stable a while.
    initial begin : compare
        logic [1:0] prev;
        int         stable;
        prev   = 2'b00;
        stable = 0;
        forever begin
            @(negedge refresh_clk);
            if ({m_busy, m_rw} == prev) begin
                if (stable < 1000) stable++;
            end else begin
                stable = 0;
            end
            prev = {m_busy, m_rw};
            if (reset && stable >= 6) begin
                chk("busy", busy, m_busy);
                if (m_busy) chk("rw", rw, m_rw);
                else if (!m_low) chk("sda_idle", sda, 1'b1);
            end
            if (rx_valid) begin
                if (exp_rx_q.size() == 0) chk("rx_valid_unexpected", rx_valid, 1'b0);
                else chk("rx_data", rx_data, exp_rx_q.pop_front());
            end
            if (tx_req) tx_seen++;
            if (stop_det) stop_seen++;
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge refresh_clk);
        #1;
    endtask

    task automatic model_rise(input int ev);
        case (ev)
            1: begin
                if (m_addr[7:1] == 7'h2A) begin
                    m_busy = 1'b1;
                    m_rw   = m_addr[0];
                    if (m_addr[0]) m_tx_exp++;
                end else begin
                    m_busy = 1'b0;
                end
            end
            2: m_busy = 1'b0;
            3: m_tx_exp++;
            default: ;
        endcase
    endtask

    task automatic bit_cycle(input logic b, input int ev, output logic rd);
        m_low = ~b;
        wait_clk(Q);
        scl = 1'b1;
        model_rise(ev);
        wait_clk(Q);
        @(negedge refresh_clk);
        rd = sda;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic bus_start();
        if (scl == 1'b0) begin
            m_low = 1'b0;
            wait_clk(Q);
            scl = 1'b1;
            wait_clk(Q);
        end
        m_low = 1'b1;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
        m_first = 1'b1;
    endtask

    task automatic bus_stop();
        m_low = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        m_low  = 1'b0;
        m_busy = 1'b0;
        m_stop_exp++;
        wait_clk(2 * Q);
    endtask

    task automatic write_byte(input logic [7:0] b);
        logic rd;
        logic exp_ack;
        if (m_first) m_addr = b;
        else if (m_busy && !m_rw) exp_rx_q.push_back(b);
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(b[i], (i == 0 && m_first) ? 1 : 0, rd);
            chk("wr_bit", rd, b[i]);
        end
        exp_ack = m_first ? m_busy : (m_busy && !m_rw);
        bit_cycle(1'b1, 0, rd);
        chk(m_first ? "addr_ack" : "data_ack", rd, exp_ack ? 1'b0 : 1'b1);
        m_first = 1'b0;
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic nack);
        logic [7:0] got;
        logic       rd;
        if (tx_q.size() != 0) tx_data = tx_q.pop_front();
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, 0, rd);
            got[i] = rd;
        end
        chk("rd_byte", got, exp);
        if (nack) begin
            bit_cycle(1'b1, 2, rd);
            chk("sda_released_after_nack", sda, 1'b1);
        end else begin
            bit_cycle(1'b0, 3, rd);
        end
    endtask

    task automatic end_check();
        wait_clk(8);
        chk("rx_pending", exp_rx_q.size(), 0);
        chk("tx_req_count", tx_seen, m_tx_exp);
        chk("stop_det_count", stop_seen, m_stop_exp);
    endtask

    initial begin : main
        int t0, s0;
        reset   = 1'b0;
        scl     = 1'b1;
        m_low   = 1'b0;
        tx_data = 8'h00;
        wait_clk(3);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_tx_req", tx_req, 1'b0);
        chk("rst_rw", rw, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_stop_det", stop_det, 1'b0);
        chk("rst_sda", sda, 1'b1);
        reset = 1'b1;
        wait_clk(10);

        // Write with address match
        s0 = stop_seen;
        bus_start();
        write_byte(8'h54);
        chk("wr_busy", busy, 1'b1);
        write_byte(8'hA5);
        write_byte(8'h3C);
        bus_stop();
        end_check();
        chk("wr_rx_last", rx_data, 8'h3C);
        chk("wr_busy_after_stop", busy, 1'b0);
        chk("wr_one_stop", stop_seen - s0, 1);

        // Address mismatch
        bus_start();
        write_byte(8'h56);
        write_byte(8'hFF);
        bus_stop();
        end_check();
        chk("mis_rx_kept", rx_data, 8'h3C);

        // Two-byte read, ACK then NACK
        t0 = tx_seen;
        tx_q.push_back(8'h7E);
        tx_data = 8'h81;
        bus_start();
        write_byte(8'h55);
        read_byte(8'h81, 1'b0);
        read_byte(8'h7E, 1'b1);
        chk("rd_busy_after_nack", busy, 1'b0);
        bus_stop();
        end_check();
        chk("rd_two_tx_req", tx_seen - t0, 2);

        // Repeated START: write then read
        tx_data = 8'hC3;
        bus_start();
        write_byte(8'h54);
        write_byte(8'h10);
        chk("rs_rw_write", rw, 1'b0);
        bus_start();
        chk("rs_busy_held", busy, 1'b1);
        write_byte(8'h55);
        chk("rs_rw_read", rw, 1'b1);
        chk("rs_busy", busy, 1'b1);
        read_byte(8'hC3, 1'b1);
        bus_stop();
        end_check();
        chk("rs_rx_data", rx_data, 8'h10);

        // Byte aborted by STOP after four data bits
        bus_start();
        write_byte(8'h54);
        for (int i = 0; i < 4; i++) bit_cycle((i % 2) == 0, 0, rd_m);
        bus_stop();
        end_check();
        chk("abort_rx_kept", rx_data, 8'h10);
        chk("abort_busy", busy, 1'b0);
        chk("abort_sda", sda, 1'b1);

        // Reset while the target drives a zero bit of 0x00
        tx_data = 8'h00;
        bus_start();
        write_byte(8'h55);
        for (int i = 0; i < 3; i++) begin
            bit_cycle(1'b1, 0, rd_m);
            chk("rst_rd_bit", rd_m, 1'b0);
        end
        m_low = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        @(negedge refresh_clk);
        chk("pre_reset_sda_low", sda, 1'b0);
        reset  = 1'b0;
        m_busy = 1'b0;
        #1;
        chk("async_sda_release", sda, 1'b1);
        chk("mid_rst_rx_data", rx_data, 8'h00);
        chk("mid_rst_rx_valid", rx_valid, 1'b0);
        chk("mid_rst_tx_req", tx_req, 1'b0);
        chk("mid_rst_rw", rw, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_stop_det", stop_det, 1'b0);
        wait_clk(2);
        scl = 1'b0;
        wait_clk(Q);
        reset = 1'b1;
        wait_clk(Q);
        bus_stop();
        bus_start();
        write_byte(8'h54);
        write_byte(8'h5A);
        bus_stop();
        end_check();
        chk("post_rst_rx_data", rx_data, 8'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
